// File: rtl/dvsd_mul_arbiter.sv
// Round-robin arbiter sharing one combinational multiplier among NREQ requesters; result valid two edges after accept.
// One operation in flight: req_ready stays low until the held result is taken via rsp_ready.
module dvsd_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*W-1:0]        req_a,
  input  logic [NREQ*W-1:0]        req_b,
  output logic [W-1:0]             mul_a,
  output logic [W-1:0]             mul_b,
  input  logic [2*W-1:0]           mul_m,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [2*W-1:0]           rsp_m,
  output logic                     busy
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] last_id, grant, idx;
  logic           grant_vld, accept, capture, release_rsp;
  logic [W-1:0]   sel_a, sel_b;

  // Round-robin search starting just after the previous winner
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_id) + k) % NREQ);
      if (!grant_vld && req_valid[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Grants only leave IDLE; reset keeps req_ready quiet even though state reads IDLE
  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    accept      = 1'b0;
    capture     = 1'b0;
    release_rsp = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld && !reset) begin
          req_ready[grant] = 1'b1;
          accept           = 1'b1;
          state_nxt        = ISSUE;
        end
      end
      ISSUE: begin
        capture   = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (rsp_ready) begin
          release_rsp = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_id   <= IDW'(NREQ - 1);
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_id    <= '0;
      rsp_m     <= '0;
      rsp_valid <= 1'b0;
    end else begin
      if (accept) begin
        last_id <= grant;
        rsp_id  <= grant;
        mul_a   <= sel_a;
        mul_b   <= sel_b;
      end
      if (capture) begin
        rsp_m     <= mul_m;
        rsp_valid <= 1'b1;
      end
      if (release_rsp) rsp_valid <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_dvsd_mul_arbiter.sv
// Randomised and directed bench for dvsd_mul_arbiter against a transaction-level model.
module tb_dvsd_mul_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [W-1:0]      mul_a, mul_b;
  logic [2*W-1:0]    mul_m;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [1:0]        rsp_id;
  logic [2*W-1:0]    rsp_m;
  logic              busy;

  dvsd_mul_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_m(rsp_m), .busy(busy)
  );

  // Stand-in for the shared combinational multiplier
  assign mul_m = (2*W)'(mul_a) * (2*W)'(mul_b);

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  // Transaction model: one job outstanding; it has a product once one edge has passed
  bit             m_busy = 0;
  bit             m_done = 0;
  int             m_last = NREQ - 1;
  int             m_id   = 0;
  logic [W-1:0]   m_a = '0, m_b = '0;
  logic [2*W-1:0] m_rspm = '0;
  int             m_g;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_last = NREQ - 1; m_id = 0;
      m_a = '0; m_b = '0; m_rspm = '0;
    end else if (m_busy) begin
      if (!m_done) begin
        m_rspm = (2*W)'(m_a) * (2*W)'(m_b);
        m_done = 1;
      end else if (rsp_ready) begin
        m_busy = 0;
        m_done = 0;
      end
    end else begin
      m_g = rr(req_valid, m_last);
      if (m_g >= 0) begin
        m_busy = 1;
        m_last = m_g;
        m_id   = m_g;
        m_a    = req_a[m_g*W +: W];
        m_b    = req_b[m_g*W +: W];
      end
    end
  end

  always @(negedge clock) begin
    int gi;
    logic [NREQ-1:0] exp_rdy;
    #2;
    gi = rr(req_valid, m_last);
    exp_rdy = '0;
    if (!reset && !m_busy && gi >= 0) exp_rdy = NREQ'(1) << gi;
    chk("m_req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("m_busy",      32'(busy),      32'(m_busy));
    chk("m_rsp_valid", 32'(rsp_valid), 32'(m_busy && m_done));
    chk("m_rsp_m",     32'(rsp_m),     32'(m_rspm));
    chk("m_rsp_id",    32'(rsp_id),    32'(m_id));
    chk("m_mul_a",     32'(mul_a),     32'(m_a));
    chk("m_mul_b",     32'(mul_b),     32'(m_b));
  end

  task automatic set_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
  endtask

  task automatic wait_idle();
    int i = 0;
    while (busy && i < 20) begin
      @(negedge clock);
      i++;
    end
    chk("idle_wait", 32'(busy), 32'(0));
  endtask

  task automatic do_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] expm);
    wait_idle();
    rsp_ready = 1'b1;
    req_valid = NREQ'(1) << id;
    set_op(id, a, b);
    #3 chk("grant", 32'(req_ready), 32'(NREQ'(1) << id));
    @(negedge clock);
    req_valid = '0;
    @(negedge clock);
    #3;
    chk("rsp_valid", 32'(rsp_valid), 32'(1));
    chk("rsp_m",     32'(rsp_m),     32'(expm));
    chk("rsp_id",    32'(rsp_id),    32'(id));
    @(negedge clock);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  int q_id[$];
  int q_m[$];
  int q_c[$];

  initial begin
    repeat (2) @(negedge clock);
    req_valid = '1;
    #3;
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_m",     32'(rsp_m),     32'(0));
    chk("rst_rsp_id",    32'(rsp_id),    32'(0));
    chk("rst_mul_a",     32'(mul_a),     32'(0));
    chk("rst_mul_b",     32'(mul_b),     32'(0));
    chk("rst_busy",      32'(busy),      32'(0));
    @(negedge clock);
    req_valid = '0;
    reset = 1'b0;

    // single request
    do_req(0, 8'd3, 8'd5, 16'd15);

    // all requesters valid straight after reset
    pulse_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, W'(i + 1), 8'd16);
    req_valid = '1;
    for (int c = 0; c < 14; c++) begin
      #3;
      if (rsp_valid) begin
        q_id.push_back(int'(rsp_id));
        q_m.push_back(int'(rsp_m));
        q_c.push_back(c);
      end
      @(negedge clock);
    end
    req_valid = '0;
    chk("rr_count", 32'(q_id.size()), 32'(4));
    for (int i = 0; i < q_id.size() && i < 4; i++) begin
      chk("rr_id", 32'(q_id[i]), 32'(i));
      chk("rr_m",  32'(q_m[i]),  32'(16 * (i + 1)));
      if (i > 0) chk("rr_gap", 32'(q_c[i] - q_c[i-1]), 32'(3));
    end

    // operand extremes
    do_req(2, 8'hFF, 8'hFF, 16'hFE01);
    do_req(1, 8'h00, 8'hFF, 16'h0000);

    // backpressure with another requester waiting
    wait_idle();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    set_op(1, 8'd7, 8'd9);
    @(negedge clock);
    req_valid = 4'b0001;
    set_op(0, 8'd2, 8'd2);
    @(negedge clock);
    @(negedge clock);
    repeat (5) begin
      #3;
      chk("bp_rsp_valid", 32'(rsp_valid), 32'(1));
      chk("bp_rsp_m",     32'(rsp_m),     32'(63));
      chk("bp_rsp_id",    32'(rsp_id),    32'(1));
      chk("bp_req_ready", 32'(req_ready), 32'(0));
      chk("bp_busy",      32'(busy),      32'(1));
      @(negedge clock);
    end
    rsp_ready = 1'b1;
    #3 chk("bp_hs_ready", 32'(req_ready), 32'(0));
    @(negedge clock);
    #3;
    chk("bp_after_valid", 32'(rsp_valid), 32'(0));
    chk("bp_after_grant", 32'(req_ready), 32'(1));
    @(negedge clock);
    req_valid = '0;

    // fairness after a grant to id 2
    do_req(2, 8'd1, 8'd1, 16'd1);
    q_id.delete();
    req_valid = 4'b1010;
    set_op(3, 8'd2, 8'd3);
    set_op(1, 8'd4, 8'd5);
    #3 chk("fair_first_grant", 32'(req_ready), 32'(4'b1000));
    for (int c = 0; c < 12; c++) begin
      if (c > 0) #3;
      if (rsp_valid) q_id.push_back(int'(rsp_id));
      @(negedge clock);
    end
    req_valid = '0;
    chk("fair_count", 32'(q_id.size() >= 2), 32'(1));
    if (q_id.size() >= 2) begin
      chk("fair_id0", 32'(q_id[0]), 32'(3));
      chk("fair_id1", 32'(q_id[1]), 32'(1));
    end

    // reset while a result is held
    wait_idle();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    set_op(1, 8'd6, 8'd6);
    @(negedge clock);
    req_valid = '0;
    @(negedge clock);
    @(negedge clock);
    #3 chk("hr_valid_before", 32'(rsp_valid), 32'(1));
    reset = 1'b1;
    #1;
    chk("hr_valid_async", 32'(rsp_valid), 32'(0));
    chk("hr_busy_async",  32'(busy),      32'(0));
    @(negedge clock);
    reset = 1'b0;
    rsp_ready = 1'b1;
    #3 chk("hr_no_ghost0", 32'(rsp_valid), 32'(0));
    @(negedge clock);
    #3 chk("hr_no_ghost1", 32'(rsp_valid), 32'(0));
    @(negedge clock);
    req_valid = '1;
    #3 chk("hr_first_id0", 32'(req_ready), 32'(1));
    @(negedge clock);
    req_valid = '0;
    wait_idle();

    // random traffic, model-checked every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      req_valid = NREQ'($urandom);
      req_a     = (NREQ*W)'($urandom);
      req_b     = (NREQ*W)'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        set_op(int'($urandom_range(0, NREQ - 1)), 8'hFF, 8'hFF);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) begin
        #3 reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
      end
    end

    @(negedge clock);
    #4;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

endmodule
